tl_buffer_queue: RTL and testbench
==================================

# tl_buffer_queue

Parametrised TileLink-UL buffer for the A (request) and D (response) channels. It sits between an upstream client node (`auto_in_*`) and a downstream manager node (`auto_out_*`) in the diplomatic interconnect. Each channel has an independently sized FIFO with optional pipe and flow modes. Depth 0 on a channel degenerates to a pure wire pass-through, so one module covers both the zero-latency buffer case and registered or decoupled cases.

## Interface
Parameters:
- `A_DEPTH`, default 2: A-channel FIFO entries, 0..8; 0 means combinational pass-through.
- `D_DEPTH`, default 2: D-channel FIFO entries, 0..8; 0 means pass-through.
- `A_PIPE`, default 0: 1 means A enq-ready is also asserted when full and dequeuing this cycle.
- `A_FLOW`, default 0: 1 means an empty A FIFO forwards enq data to deq in the same cycle.
- `D_PIPE`, default 0: as `A_PIPE`, for D.
- `D_FLOW`, default 0: as `A_FLOW`, for D.
- `SOURCE_W`, default 9: source-ID width.
- `ADDR_W`, default 31: address width.
- `DATA_W`, default 64: data width; mask width is `DATA_W/8`.

Ports:
- `clock`  in  1: sole clock; all state on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `auto_in_a_valid` in 1 / `auto_in_a_ready` out 1: upstream A handshake.
- `auto_in_a_bits_{opcode,param,size,source,address,mask,data,corrupt}`  in  3/3/2/SOURCE_W/ADDR_W/DATA_W/8/DATA_W/1: A payload.
- `auto_out_a_valid` out 1 / `auto_out_a_ready` in 1: downstream A handshake.
- `auto_out_a_bits_*`  out: same fields and widths as `auto_in_a_bits_*`.
- `auto_out_d_valid` in 1 / `auto_out_d_ready` out 1: downstream D handshake.
- `auto_out_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}`  in  3/2/2/SOURCE_W/1/1/DATA_W/1: D payload.
- `auto_in_d_valid` out 1 / `auto_in_d_ready` in 1: upstream D handshake.
- `auto_in_d_bits_*`  out: same fields and widths as `auto_out_d_bits_*`.
- `a_count` out clog2(A_DEPTH+1): A FIFO occupancy, for debug and perf.
- `d_count` out clog2(D_DEPTH+1): D FIFO occupancy.

## Operation
- A: enq side is `auto_in_a`, deq side is `auto_out_a`. D: enq side is `auto_out_d`, deq side is `auto_in_d`. The two channels are fully independent.
- DEPTH=0: every field, valid and ready is wired straight through. Count is a constant 0.
- DEPTH>0: payload RAM of DEPTH entries, `enq_ptr`, `deq_ptr` (0..DEPTH-1, wrap to 0 after DEPTH-1), and a `maybe_full` flag.
  - empty = ptrs equal and !maybe_full; full = ptrs equal and maybe_full.
  - Non-power-of-2 DEPTH wraps explicitly at DEPTH-1.
- do_enq = enq_valid & enq_ready; do_deq = deq_valid & deq_ready.
- enq_ready = !full | (PIPE & deq_ready).
- deq_valid = !empty | (FLOW & enq_valid).
- deq data = RAM[deq_ptr], or the enq payload when FLOW & empty.
- FLOW & empty & do_enq & do_deq: the beat bypasses; RAM, pointers and count are unchanged.
- Otherwise do_enq writes RAM[enq_ptr] and advances enq_ptr; do_deq advances deq_ptr.
- On do_enq != do_deq, `maybe_full` <= do_enq.
- count = (enq_ptr - deq_ptr) mod DEPTH, or DEPTH when full.
- Payload is never modified, reordered or dropped. Order is strict FIFO per channel.
- Bus-protocol checks are out of scope.

## Timing
- Reset (synchronous): pointers 0, `maybe_full` 0, counts 0.
  - After the reset edge: deq valid = 0 (FLOW=0), enq ready = 1.
  - During reset, ready and valid are still driven combinationally from state; the integrating module masks traffic.
  - Reset mid-transfer discards all stored beats. RAM contents are not cleared and are unobservable.
- Latency, FLOW=0: 1 cycle min enq-to-deq (beat accepted at edge N is valid after edge N).
- Latency, FLOW=1 and empty: 0 cycles.
- Throughput is 1 beat/cycle per channel when DEPTH>=2, or when DEPTH=1 with PIPE=1.
- DEPTH=1, PIPE=0: 1 beat every 2 cycles.
- Full with simultaneous enq and deq (PIPE=1): both occur, count unchanged.
- Empty with simultaneous enq and deq: only possible with FLOW=1 (bypass).
- Deq payload and valid stay stable while deq_ready=0.

## Test plan
- Reset then idle, A_DEPTH=2: `auto_out_a_valid`=0, `auto_in_a_ready`=1, `a_count`=0. Send one Get (opcode 4, address 0x1000, source 5) -> valid at `auto_out_a` 1 cycle later, fields identical.
- Fill, A_DEPTH=2, out_ready=0: push 3 beats -> `auto_in_a_ready` drops after 2, `a_count`=2. Release ready -> data 0xA, 0xB emerge in order, then the third beat.
- Wrap, D_DEPTH=3: stream 10 AccessAckData beats (data=i) with random `auto_in_d_ready` -> all 10 delivered in order; `d_count` never exceeds 3.
- PIPE, A_DEPTH=1, A_PIPE=1: ready held 1 with continuous valid -> 1 beat/cycle. Same with A_PIPE=0 -> 1 beat every 2 cycles.
- FLOW, D_DEPTH=2, D_FLOW=1, empty: `auto_out_d_valid`=1, source 0x1FF, `auto_in_d_ready`=1 -> same-cycle `auto_in_d_valid`=1 with source 0x1FF; `d_count` stays 0.
- DEPTH=0 both channels, and reset asserted with 2 beats queued: pass-through is combinational and equal on all fields. After reset the count returns to 0 and no stale beat appears.

Source files
------------

// File: rtl/tl_buffer_queue.sv
// TileLink-UL A/D channel buffer: one independently sized FIFO per channel.
// A FIFO of depth 0 collapses to plain wires between its enq and deq sides.

module tl_buffer_queue_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8,
    parameter bit          PIPE  = 1'b0,
    parameter bit          FLOW  = 1'b0,
    parameter int unsigned CW    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [CW-1:0]    count
);
    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clock ^ reset;
        assign enq_ready      = deq_ready;
        assign deq_valid      = enq_valid;
        assign deq_bits       = enq_bits;
        assign count          = '0;
    end else begin : g_fifo
        localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

        logic [WIDTH-1:0] ram [DEPTH];
        logic [PW-1:0]    enq_ptr;
        logic [PW-1:0]    deq_ptr;
        logic             maybe_full;
        logic             ptr_match;
        logic             empty;
        logic             full;
        logic             do_enq;
        logic             do_deq;
        logic             bypass;
        logic             wr;
        logic             rd;

        // Explicit wrap so non-power-of-2 depths work.
        function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
            return (p == LAST) ? '0 : PW'(p + 1'b1);
        endfunction

        assign ptr_match = (enq_ptr == deq_ptr);
        assign empty     = ptr_match && !maybe_full;
        assign full      = ptr_match && maybe_full;

        assign enq_ready = !full || (PIPE && deq_ready);
        assign deq_valid = !empty || (FLOW && enq_valid);
        assign deq_bits  = (FLOW && empty) ? enq_bits : ram[deq_ptr];

        assign do_enq = enq_valid && enq_ready;
        assign do_deq = deq_valid && deq_ready;
        // A flow-through beat on an empty queue never touches storage.
        assign bypass = FLOW && empty && do_enq && do_deq;
        assign wr     = do_enq && !bypass;
        assign rd     = do_deq && !bypass;

        always_ff @(posedge clock) begin
            if (reset) begin
                enq_ptr    <= '0;
                deq_ptr    <= '0;
                maybe_full <= 1'b0;
            end else begin
                if (wr) enq_ptr <= next_ptr(enq_ptr);
                if (rd) deq_ptr <= next_ptr(deq_ptr);
                if (wr != rd) maybe_full <= wr;
            end
        end

        always_ff @(posedge clock) begin
            if (wr) ram[enq_ptr] <= enq_bits;
        end

        always_comb begin
            if (full) begin
                count = CW'(DEPTH);
            end else if (enq_ptr >= deq_ptr) begin
                count = CW'(enq_ptr) - CW'(deq_ptr);
            end else begin
                count = CW'(DEPTH) - CW'(deq_ptr) + CW'(enq_ptr);
            end
        end
    end
endmodule

module tl_buffer_queue #(
    parameter int unsigned A_DEPTH  = 2,
    parameter int unsigned D_DEPTH  = 2,
    parameter bit          A_PIPE   = 1'b0,
    parameter bit          A_FLOW   = 1'b0,
    parameter bit          D_PIPE   = 1'b0,
    parameter bit          D_FLOW   = 1'b0,
    parameter int unsigned SOURCE_W = 9,
    parameter int unsigned ADDR_W   = 31,
    parameter int unsigned DATA_W   = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  auto_in_a_valid,
    output logic                  auto_in_a_ready,
    input  logic [2:0]            auto_in_a_bits_opcode,
    input  logic [2:0]            auto_in_a_bits_param,
    input  logic [1:0]            auto_in_a_bits_size,
    input  logic [SOURCE_W-1:0]   auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]     auto_in_a_bits_address,
    input  logic [DATA_W/8-1:0]   auto_in_a_bits_mask,
    input  logic [DATA_W-1:0]     auto_in_a_bits_data,
    input  logic                  auto_in_a_bits_corrupt,
    output logic                  auto_out_a_valid,
    input  logic                  auto_out_a_ready,
    output logic [2:0]            auto_out_a_bits_opcode,
    output logic [2:0]            auto_out_a_bits_param,
    output logic [1:0]            auto_out_a_bits_size,
    output logic [SOURCE_W-1:0]   auto_out_a_bits_source,
    output logic [ADDR_W-1:0]     auto_out_a_bits_address,
    output logic [DATA_W/8-1:0]   auto_out_a_bits_mask,
    output logic [DATA_W-1:0]     auto_out_a_bits_data,
    output logic                  auto_out_a_bits_corrupt,
    input  logic                  auto_out_d_valid,
    output logic                  auto_out_d_ready,
    input  logic [2:0]            auto_out_d_bits_opcode,
    input  logic [1:0]            auto_out_d_bits_param,
    input  logic [1:0]            auto_out_d_bits_size,
    input  logic [SOURCE_W-1:0]   auto_out_d_bits_source,
    input  logic                  auto_out_d_bits_sink,
    input  logic                  auto_out_d_bits_denied,
    input  logic [DATA_W-1:0]     auto_out_d_bits_data,
    input  logic                  auto_out_d_bits_corrupt,
    output logic                  auto_in_d_valid,
    input  logic                  auto_in_d_ready,
    output logic [2:0]            auto_in_d_bits_opcode,
    output logic [1:0]            auto_in_d_bits_param,
    output logic [1:0]            auto_in_d_bits_size,
    output logic [SOURCE_W-1:0]   auto_in_d_bits_source,
    output logic                  auto_in_d_bits_sink,
    output logic                  auto_in_d_bits_denied,
    output logic [DATA_W-1:0]     auto_in_d_bits_data,
    output logic                  auto_in_d_bits_corrupt,
    output logic [((A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1))-1:0] a_count,
    output logic [((D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1))-1:0] d_count
);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned A_W    = 3 + 3 + 2 + SOURCE_W + ADDR_W + MASK_W + DATA_W + 1;
    localparam int unsigned D_W    = 3 + 2 + 2 + SOURCE_W + 1 + 1 + DATA_W + 1;
    localparam int unsigned A_CW   = (A_DEPTH == 0) ? 1 : $clog2(A_DEPTH + 1);
    localparam int unsigned D_CW   = (D_DEPTH == 0) ? 1 : $clog2(D_DEPTH + 1);

    logic [A_W-1:0] a_enq;
    logic [A_W-1:0] a_deq;
    logic [D_W-1:0] d_enq;
    logic [D_W-1:0] d_deq;

    // Payloads travel through each FIFO as one flat word.
    assign a_enq = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                    auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                    auto_in_a_bits_data, auto_in_a_bits_corrupt};
    assign {auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
            auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
            auto_out_a_bits_data, auto_out_a_bits_corrupt} = a_deq;

    assign d_enq = {auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                    auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                    auto_out_d_bits_data, auto_out_d_bits_corrupt};
    assign {auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
            auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
            auto_in_d_bits_data, auto_in_d_bits_corrupt} = d_deq;

    tl_buffer_queue_fifo #(
        .DEPTH(A_DEPTH), .WIDTH(A_W), .PIPE(A_PIPE), .FLOW(A_FLOW), .CW(A_CW)
    ) u_a_fifo (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_in_a_valid),
        .enq_ready (auto_in_a_ready),
        .enq_bits  (a_enq),
        .deq_valid (auto_out_a_valid),
        .deq_ready (auto_out_a_ready),
        .deq_bits  (a_deq),
        .count     (a_count)
    );

    tl_buffer_queue_fifo #(
        .DEPTH(D_DEPTH), .WIDTH(D_W), .PIPE(D_PIPE), .FLOW(D_FLOW), .CW(D_CW)
    ) u_d_fifo (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (auto_out_d_valid),
        .enq_ready (auto_out_d_ready),
        .enq_bits  (d_enq),
        .deq_valid (auto_in_d_valid),
        .deq_ready (auto_in_d_ready),
        .deq_bits  (d_deq),
        .count     (d_count)
    );
endmodule

// File: tb/tb_tl_buffer_queue.sv
// Bench for tl_buffer_queue: four instances covering depth/pipe/flow variants,
// directed steps plus randomized traffic scored against queue-based models.

module tb_tl_buffer_queue;
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [8:0]  source;
        logic [30:0] address;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        corrupt;
    } a_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [1:0]  size;
        logic [8:0]  source;
        logic        sink;
        logic        denied;
        logic [63:0] data;
        logic        corrupt;
    } d_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic in_a_valid [4];
    logic in_a_ready [4];
    logic out_a_valid [4];
    logic out_a_ready [4];
    a_t   in_a_bits [4];
    a_t   out_a_bits [4];
    logic out_d_valid [4];
    logic out_d_ready [4];
    logic in_d_valid [4];
    logic in_d_ready [4];
    d_t   out_d_bits [4];
    d_t   in_d_bits [4];
    logic [3:0] a_cnt [4];
    logic [3:0] d_cnt [4];

    int ncmp = 0;
    int nfail = 0;

    // Instance 0: A depth 2, D depth 3.  Instance 1: A depth 1 pipe, D depth 2 flow.
    // Instance 2: A depth 1 no pipe.     Instance 3: both channels depth 0.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned AD  = (g == 0) ? 2 : (g == 3) ? 0 : 1;
        localparam int unsigned DD  = (g == 0) ? 3 : (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int unsigned ACW = (AD == 0) ? 1 : $clog2(AD + 1);
        localparam int unsigned DCW = (DD == 0) ? 1 : $clog2(DD + 1);
        logic [ACW-1:0] ac;
        logic [DCW-1:0] dc;
        assign a_cnt[g] = 4'(ac);
        assign d_cnt[g] = 4'(dc);

        tl_buffer_queue #(
            .A_DEPTH(AD), .D_DEPTH(DD), .A_PIPE(g == 1), .A_FLOW(1'b0),
            .D_PIPE(1'b0), .D_FLOW(g == 1), .SOURCE_W(9), .ADDR_W(31), .DATA_W(64)
        ) u_dut (
            .clock                   (clock),
            .reset                   (reset),
            .auto_in_a_valid         (in_a_valid[g]),
            .auto_in_a_ready         (in_a_ready[g]),
            .auto_in_a_bits_opcode   (in_a_bits[g].opcode),
            .auto_in_a_bits_param    (in_a_bits[g].param),
            .auto_in_a_bits_size     (in_a_bits[g].size),
            .auto_in_a_bits_source   (in_a_bits[g].source),
            .auto_in_a_bits_address  (in_a_bits[g].address),
            .auto_in_a_bits_mask     (in_a_bits[g].mask),
            .auto_in_a_bits_data     (in_a_bits[g].data),
            .auto_in_a_bits_corrupt  (in_a_bits[g].corrupt),
            .auto_out_a_valid        (out_a_valid[g]),
            .auto_out_a_ready        (out_a_ready[g]),
            .auto_out_a_bits_opcode  (out_a_bits[g].opcode),
            .auto_out_a_bits_param   (out_a_bits[g].param),
            .auto_out_a_bits_size    (out_a_bits[g].size),
            .auto_out_a_bits_source  (out_a_bits[g].source),
            .auto_out_a_bits_address (out_a_bits[g].address),
            .auto_out_a_bits_mask    (out_a_bits[g].mask),
            .auto_out_a_bits_data    (out_a_bits[g].data),
            .auto_out_a_bits_corrupt (out_a_bits[g].corrupt),
            .auto_out_d_valid        (out_d_valid[g]),
            .auto_out_d_ready        (out_d_ready[g]),
            .auto_out_d_bits_opcode  (out_d_bits[g].opcode),
            .auto_out_d_bits_param   (out_d_bits[g].param),
            .auto_out_d_bits_size    (out_d_bits[g].size),
            .auto_out_d_bits_source  (out_d_bits[g].source),
            .auto_out_d_bits_sink    (out_d_bits[g].sink),
            .auto_out_d_bits_denied  (out_d_bits[g].denied),
            .auto_out_d_bits_data    (out_d_bits[g].data),
            .auto_out_d_bits_corrupt (out_d_bits[g].corrupt),
            .auto_in_d_valid         (in_d_valid[g]),
            .auto_in_d_ready         (in_d_ready[g]),
            .auto_in_d_bits_opcode   (in_d_bits[g].opcode),
            .auto_in_d_bits_param    (in_d_bits[g].param),
            .auto_in_d_bits_size     (in_d_bits[g].size),
            .auto_in_d_bits_source   (in_d_bits[g].source),
            .auto_in_d_bits_sink     (in_d_bits[g].sink),
            .auto_in_d_bits_denied   (in_d_bits[g].denied),
            .auto_in_d_bits_data     (in_d_bits[g].data),
            .auto_in_d_bits_corrupt  (in_d_bits[g].corrupt),
            .a_count                 (ac),
            .d_count                 (dc)
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    function automatic a_t mk_a(input logic [63:0] data);
        a_t b;
        b.opcode  = 3'($urandom);
        b.param   = 3'($urandom);
        b.size    = 2'($urandom);
        b.source  = 9'($urandom);
        b.address = 31'($urandom);
        b.mask    = 8'($urandom);
        b.data    = data;
        b.corrupt = 1'($urandom);
        return b;
    endfunction

    function automatic d_t mk_d(input logic [63:0] data);
        d_t b;
        b.opcode  = 3'($urandom);
        b.param   = 2'($urandom);
        b.size    = 2'($urandom);
        b.source  = 9'($urandom);
        b.sink    = 1'($urandom);
        b.denied  = 1'($urandom);
        b.data    = data;
        b.corrupt = 1'($urandom);
        return b;
    endfunction

    // A-channel traffic against an ideal FIFO of capacity dep; ends with a drain.
    task automatic run_a(input int k, input int dep, input bit pipe, input int ncyc,
                         input bit rnd, output int ndeq);
        a_t q[$];
        a_t b;
        logic fi, fo;
        bit drain;
        ndeq = 0;
        for (int c = 0; c < ncyc + dep + 1; c++) begin
            drain = (c >= ncyc);
            b = rnd ? mk_a({$urandom, $urandom}) : mk_a(64'(c));
            in_a_bits[k]   = b;
            in_a_valid[k]  = drain ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            out_a_ready[k] = drain ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            settle();
            chk("a_valid", 128'(out_a_valid[k]), 128'(q.size() > 0));
            chk("a_ready", 128'(in_a_ready[k]), 128'((q.size() < dep) || (pipe && out_a_ready[k])));
            chk("a_count", 128'(a_cnt[k]), 128'(q.size()));
            fi = in_a_valid[k] && in_a_ready[k];
            fo = out_a_valid[k] && out_a_ready[k];
            if (fo && q.size() > 0) begin
                chk("a_order", 128'(out_a_bits[k]), 128'(q.pop_front()));
                if (!drain) ndeq++;
            end
            if (fi) q.push_back(b);
            adv();
        end
        in_a_valid[k] = 1'b0;
    endtask

    // D-channel stream of ten AccessAckData beats, data = beat index, random backpressure.
    task automatic run_d(input int k, input int dep, output int ndel);
        d_t q[$];
        d_t b;
        int nsent;
        logic fi, fo;
        nsent = 0;
        ndel = 0;
        for (int c = 0; c < 300 && ndel < 10; c++) begin
            b = mk_d(64'(nsent));
            b.opcode = 3'd1;
            out_d_bits[k]  = b;
            out_d_valid[k] = (nsent < 10) && ($urandom_range(0, 3) != 0);
            in_d_ready[k]  = 1'($urandom_range(0, 1));
            settle();
            chk("d_valid", 128'(in_d_valid[k]), 128'(q.size() > 0));
            chk("d_ready", 128'(out_d_ready[k]), 128'(q.size() < dep));
            chk("d_count", 128'(d_cnt[k]), 128'(q.size()));
            fi = out_d_valid[k] && out_d_ready[k];
            fo = in_d_valid[k] && in_d_ready[k];
            if (fo && q.size() > 0) begin
                chk("d_order", 128'(in_d_bits[k]), 128'(q.pop_front()));
                ndel++;
            end
            if (fi) begin
                q.push_back(b);
                nsent++;
            end
            adv();
        end
        out_d_valid[k] = 1'b0;
        in_d_ready[k]  = 1'b0;
    endtask

    initial begin
        a_t get, b0, b1, b2;
        d_t e0, e1;
        int n;
        logic v, r, dv, dr;

        for (int i = 0; i < 4; i++) begin
            in_a_valid[i]  = 1'b0;
            out_a_ready[i] = 1'b0;
            in_a_bits[i]   = '0;
            out_d_valid[i] = 1'b0;
            in_d_ready[i]  = 1'b0;
            out_d_bits[i]  = '0;
        end
        reset = 1'b1;
        adv();
        adv();
        reset = 1'b0;
        settle();
        chk("rst_a_valid", 128'(out_a_valid[0]), 128'(1'b0));
        chk("rst_a_ready", 128'(in_a_ready[0]), 128'(1'b1));
        chk("rst_a_count", 128'(a_cnt[0]), 128'(0));
        chk("rst_d_valid", 128'(in_d_valid[0]), 128'(1'b0));
        chk("rst_d_ready", 128'(out_d_ready[0]), 128'(1'b1));
        chk("rst_d_count", 128'(d_cnt[0]), 128'(0));
        adv();

        // Single Get through A depth 2: visible one cycle after acceptance.
        get = '{opcode: 3'd4, param: 3'd0, size: 2'd3, source: 9'd5, address: 31'h1000,
                mask: 8'hff, data: 64'd0, corrupt: 1'b0};
        in_a_bits[0] = get;
        in_a_valid[0] = 1'b1;
        out_a_ready[0] = 1'b1;
        settle();
        chk("get_not_same_cycle", 128'(out_a_valid[0]), 128'(1'b0));
        adv();
        in_a_valid[0] = 1'b0;
        settle();
        chk("get_valid", 128'(out_a_valid[0]), 128'(1'b1));
        chk("get_bits", 128'(out_a_bits[0]), 128'(get));
        chk("get_count", 128'(a_cnt[0]), 128'(1));
        adv();
        settle();
        chk("get_gone", 128'(out_a_valid[0]), 128'(1'b0));
        chk("get_count0", 128'(a_cnt[0]), 128'(0));
        adv();

        // Fill with deq stalled, then release.
        b0 = mk_a(64'hA);
        b1 = mk_a(64'hB);
        b2 = mk_a(64'hC);
        out_a_ready[0] = 1'b0;
        in_a_bits[0] = b0;
        in_a_valid[0] = 1'b1;
        settle();
        chk("fill_rdy0", 128'(in_a_ready[0]), 128'(1'b1));
        adv();
        in_a_bits[0] = b1;
        settle();
        chk("fill_rdy1", 128'(in_a_ready[0]), 128'(1'b1));
        chk("fill_vld1", 128'(out_a_valid[0]), 128'(1'b1));
        adv();
        in_a_bits[0] = b2;
        settle();
        chk("fill_full_rdy", 128'(in_a_ready[0]), 128'(1'b0));
        chk("fill_full_cnt", 128'(a_cnt[0]), 128'(2));
        adv();
        out_a_ready[0] = 1'b1;
        settle();
        chk("fill_out0", 128'(out_a_bits[0]), 128'(b0));
        chk("fill_nopipe_rdy", 128'(in_a_ready[0]), 128'(1'b0));
        adv();
        settle();
        chk("fill_out1", 128'(out_a_bits[0]), 128'(b1));
        chk("fill_rdy_again", 128'(in_a_ready[0]), 128'(1'b1));
        adv();
        in_a_valid[0] = 1'b0;
        settle();
        chk("fill_out2", 128'(out_a_bits[0]), 128'(b2));
        chk("fill_cnt1", 128'(a_cnt[0]), 128'(1));
        adv();
        settle();
        chk("fill_empty", 128'(out_a_valid[0]), 128'(1'b0));
        adv();

        // Reset with two beats queued on both channels discards them.
        out_a_ready[0] = 1'b0;
        in_d_ready[0] = 1'b0;
        in_a_valid[0] = 1'b1;
        out_d_valid[0] = 1'b1;
        in_a_bits[0] = mk_a(64'h1);
        out_d_bits[0] = mk_d(64'h1);
        adv();
        in_a_bits[0] = mk_a(64'h2);
        out_d_bits[0] = mk_d(64'h2);
        adv();
        in_a_valid[0] = 1'b0;
        out_d_valid[0] = 1'b0;
        settle();
        chk("pre_rst_a_cnt", 128'(a_cnt[0]), 128'(2));
        chk("pre_rst_d_cnt", 128'(d_cnt[0]), 128'(2));
        reset = 1'b1;
        adv();
        reset = 1'b0;
        settle();
        chk("mid_rst_a_cnt", 128'(a_cnt[0]), 128'(0));
        chk("mid_rst_d_cnt", 128'(d_cnt[0]), 128'(0));
        chk("mid_rst_a_vld", 128'(out_a_valid[0]), 128'(1'b0));
        chk("mid_rst_d_vld", 128'(in_d_valid[0]), 128'(1'b0));
        chk("mid_rst_a_rdy", 128'(in_a_ready[0]), 128'(1'b1));
        adv();
        b0 = mk_a(64'h77);
        in_a_bits[0] = b0;
        in_a_valid[0] = 1'b1;
        out_a_ready[0] = 1'b1;
        adv();
        in_a_valid[0] = 1'b0;
        settle();
        chk("post_rst_fresh", 128'(out_a_bits[0]), 128'(b0));
        adv();
        settle();
        chk("post_rst_empty", 128'(a_cnt[0]), 128'(0));
        adv();

        run_a(0, 2, 1'b0, 80, 1'b1, n);
        run_d(0, 3, n);
        chk("d_wrap_delivered", 128'(n), 128'(10));

        // Full-rate streaming: depth 1 with pipe gives 7 deqs in 8 cycles, without pipe 4.
        run_a(1, 1, 1'b1, 8, 1'b0, n);
        chk("pipe1_tput", 128'(n), 128'(7));
        run_a(2, 1, 1'b0, 8, 1'b0, n);
        chk("pipe0_tput", 128'(n), 128'(4));

        // Flow-through on empty D (instance 1).
        e0 = mk_d({$urandom, $urandom});
        e0.source = 9'h1FF;
        out_d_bits[1] = e0;
        out_d_valid[1] = 1'b1;
        in_d_ready[1] = 1'b1;
        settle();
        chk("flow_valid", 128'(in_d_valid[1]), 128'(1'b1));
        chk("flow_bits", 128'(in_d_bits[1]), 128'(e0));
        chk("flow_ready", 128'(out_d_ready[1]), 128'(1'b1));
        chk("flow_cnt", 128'(d_cnt[1]), 128'(0));
        adv();
        out_d_valid[1] = 1'b0;
        settle();
        chk("flow_after_cnt", 128'(d_cnt[1]), 128'(0));
        chk("flow_after_vld", 128'(in_d_valid[1]), 128'(1'b0));
        adv();
        e1 = mk_d({$urandom, $urandom});
        out_d_bits[1] = e1;
        out_d_valid[1] = 1'b1;
        in_d_ready[1] = 1'b0;
        settle();
        chk("flow_stall_vld", 128'(in_d_valid[1]), 128'(1'b1));
        chk("flow_stall_bits", 128'(in_d_bits[1]), 128'(e1));
        adv();
        out_d_valid[1] = 1'b0;
        out_d_bits[1] = mk_d({$urandom, $urandom});
        in_d_ready[1] = 1'b1;
        settle();
        chk("flow_stored_bits", 128'(in_d_bits[1]), 128'(e1));
        chk("flow_stored_cnt", 128'(d_cnt[1]), 128'(1));
        adv();
        settle();
        chk("flow_drained", 128'(d_cnt[1]), 128'(0));
        adv();

        // Depth 0 on both channels: pure wires.
        for (int i = 0; i < 6; i++) begin
            b0 = mk_a({$urandom, $urandom});
            e0 = mk_d({$urandom, $urandom});
            v  = 1'($urandom);
            r  = 1'($urandom);
            dv = 1'($urandom);
            dr = 1'($urandom);
            in_a_bits[3] = b0;
            in_a_valid[3] = v;
            out_a_ready[3] = r;
            out_d_bits[3] = e0;
            out_d_valid[3] = dv;
            in_d_ready[3] = dr;
            settle();
            chk("wire_a_bits", 128'(out_a_bits[3]), 128'(b0));
            chk("wire_a_valid", 128'(out_a_valid[3]), 128'(v));
            chk("wire_a_ready", 128'(in_a_ready[3]), 128'(r));
            chk("wire_a_cnt", 128'(a_cnt[3]), 128'(0));
            chk("wire_d_bits", 128'(in_d_bits[3]), 128'(e0));
            chk("wire_d_valid", 128'(in_d_valid[3]), 128'(dv));
            chk("wire_d_ready", 128'(out_d_ready[3]), 128'(dr));
            chk("wire_d_cnt", 128'(d_cnt[3]), 128'(0));
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
